// File: rtl/mem_port_arbiter.sv
// Arbiter that shares one unified memory port between instruction fetch (read only)
// and the data stage (read/write). D-side wins ties, limited by a bounded streak count.
module mem_port_arbiter #(
    parameter int WORD_SIZE    = 16,
    parameter int D_STREAK_MAX = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    input  logic                 i_cancel,
    output logic                 i_ack,
    output logic [WORD_SIZE-1:0] i_rdata,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic                 d_ack,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 readM,
    output logic                 writeM,
    output logic [WORD_SIZE-1:0] address,
    inout  wire  [WORD_SIZE-1:0] data,
    input  logic                 mem_ack
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    localparam logic [2:0] STREAK_MAX = 3'(D_STREAK_MAX);

    state_t               state_q,   state_d;
    logic [WORD_SIZE-1:0] address_q, address_d;
    logic [WORD_SIZE-1:0] wbuf_q,    wbuf_d;
    logic [WORD_SIZE-1:0] i_rdata_q, i_rdata_d;
    logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;
    logic                 readM_q,   readM_d;
    logic                 writeM_q,  writeM_d;
    logic                 i_ack_q,   i_ack_d;
    logic                 d_ack_q,   d_ack_d;
    logic                 cancel_q,  cancel_d;
    logic [2:0]           streak_q,  streak_d;

    logic i_eff;
    logic grant_d;
    logic grant_i;

    // A fetch flushed in the same cycle it is requested is treated as absent.
    assign i_eff   = i_req && !i_cancel;
    assign grant_d = (state_q == IDLE) && d_req && !(i_eff && (streak_q == STREAK_MAX));
    assign grant_i = (state_q == IDLE) && i_eff && !grant_d;

    always_comb begin
        state_d   = state_q;
        address_d = address_q;
        wbuf_d    = wbuf_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        readM_d   = readM_q;
        writeM_d  = writeM_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        cancel_d  = cancel_q;
        streak_d  = streak_q;

        unique case (state_q)
            IDLE: begin
                if (grant_d) begin
                    address_d = d_addr;
                    wbuf_d    = d_wdata;
                    readM_d   = !d_we;
                    writeM_d  = d_we;
                    state_d   = BUSY_D;
                    if (!i_eff) begin
                        streak_d = 3'd0;
                    end else if (streak_q != STREAK_MAX) begin
                        streak_d = streak_q + 3'd1;
                    end
                end else if (grant_i) begin
                    address_d = i_addr;
                    readM_d   = 1'b1;
                    writeM_d  = 1'b0;
                    state_d   = BUSY_I;
                    streak_d  = 3'd0;
                    cancel_d  = 1'b0;
                end
            end
            BUSY_I: begin
                if (mem_ack) begin
                    readM_d  = 1'b0;
                    state_d  = IDLE;
                    cancel_d = 1'b0;
                    // A flush seen on the completion edge still suppresses the result.
                    if (!(cancel_q || i_cancel)) begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = data;
                    end
                end else if (i_cancel) begin
                    cancel_d = 1'b1;
                end
            end
            BUSY_D: begin
                if (mem_ack) begin
                    readM_d  = 1'b0;
                    writeM_d = 1'b0;
                    state_d  = IDLE;
                    d_ack_d  = 1'b1;
                    if (!writeM_q) begin
                        d_rdata_d = data;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                readM_d  = 1'b0;
                writeM_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            address_q <= '0;
            wbuf_q    <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            readM_q   <= 1'b0;
            writeM_q  <= 1'b0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            cancel_q  <= 1'b0;
            streak_q  <= 3'd0;
        end else begin
            state_q   <= state_d;
            address_q <= address_d;
            wbuf_q    <= wbuf_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            readM_q   <= readM_d;
            writeM_q  <= writeM_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            cancel_q  <= cancel_d;
            streak_q  <= streak_d;
        end
    end

    assign i_ack   = i_ack_q;
    assign d_ack   = d_ack_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign readM   = readM_q;
    assign writeM  = writeM_q;
    assign address = address_q;
    assign data    = writeM_q ? wbuf_q : {WORD_SIZE{1'bz}};

endmodule
